// File: rtl/oam_dma_pkg.sv
// Shared constants for the sprite DMA engine: FSM state encoding, transfer
// geometry and the PPU register map used to locate OAMDATA.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    DMA_IDLE,
    DMA_WAITHALT,
    DMA_DUMMY,
    DMA_RD,
    DMA_WR,
    DMA_FIN
  } DmaState;

  // PPU registers decode on 8-byte boundaries and mirror through $3FFF.
  localparam logic [15:0] PPU_REG_BASE    = 16'h2000;
  localparam logic [15:0] PPU_MIRROR_MASK = 16'h0007;
  localparam logic [15:0] OAMDATA_OFFSET  = 16'h0004;
  localparam logic [15:0] OAMDATA_ADDR    = PPU_REG_BASE | (OAMDATA_OFFSET & PPU_MIRROR_MASK);

  localparam int DMA_LEN          = 256;
  localparam int DMA_DUMMY_CYCLES = 1;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: halts the CPU and copies one 256-byte page to OAMDATA
// through the arbiter's DMA master port with a strict level req/ack handshake.
module oam_dma
  import oam_dma_pkg::*;
#(
  parameter logic [15:0] DEST_ADDR = OAMDATA_ADDR,
  parameter int          LEN       = DMA_LEN,
  parameter int          DUMMY     = DMA_DUMMY_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  page,
  input  logic        cpudone,
  input  logic        cyctick,
  output logic        halt,
  output logic [15:0] dmaaddr,
  output logic [7:0]  dmawdata,
  output logic        dmawr,
  output logic        dmareq,
  input  logic        dmaack,
  input  logic [7:0]  memrdata,
  output logic        dmadone,
  output logic        busy
);

  localparam logic [8:0] LAST_INDEX = 9'(LEN - 1);
  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY - 1);
  localparam DmaState    AFTER_HALT = (DUMMY == 0) ? DMA_RD : DMA_DUMMY;

  DmaState     r_state;
  logic [7:0]  r_page;
  logic [8:0]  r_index;
  logic [3:0]  r_dummyCnt;
  logic        r_halt;
  logic        r_req;
  logic        r_wr;
  logic [15:0] r_addr;
  logic [7:0]  r_wdata;
  logic        r_done;
  logic        r_busy;

  // An ack only counts while our request is up; dropping req on the ack edge
  // guarantees one low clk before the next request can rise on a cyctick.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= DMA_IDLE;
      r_page     <= '0;
      r_index    <= '0;
      r_dummyCnt <= '0;
      r_halt     <= 1'b0;
      r_req      <= 1'b0;
      r_wr       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        DMA_IDLE: begin
          if (start) begin
            r_page  <= page;
            r_index <= '0;
            r_busy  <= 1'b1;
            r_state <= DMA_WAITHALT;
          end
        end
        DMA_WAITHALT: begin
          if (cpudone) begin
            r_halt     <= 1'b1;
            r_dummyCnt <= '0;
            r_state    <= AFTER_HALT;
          end
        end
        DMA_DUMMY: begin
          if (cyctick) begin
            r_done <= 1'b1;
            if (r_dummyCnt == DUMMY_LAST) begin
              r_state <= DMA_RD;
            end else begin
              r_dummyCnt <= r_dummyCnt + 4'd1;
            end
          end
        end
        DMA_RD: begin
          if (r_req) begin
            if (dmaack) begin
              r_wdata <= memrdata;
              r_req   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= DMA_WR;
            end
          end else if (cyctick) begin
            r_req  <= 1'b1;
            r_wr   <= 1'b0;
            r_addr <= {r_page, r_index[7:0]};
          end
        end
        DMA_WR: begin
          if (r_req) begin
            if (dmaack) begin
              r_req   <= 1'b0;
              r_done  <= 1'b1;
              r_index <= r_index + 9'd1;
              r_state <= (r_index == LAST_INDEX) ? DMA_FIN : DMA_RD;
            end
          end else if (cyctick) begin
            r_req  <= 1'b1;
            r_wr   <= 1'b1;
            r_addr <= DEST_ADDR;
          end
        end
        DMA_FIN: begin
          r_halt  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= DMA_IDLE;
        end
        default: r_state <= DMA_IDLE;
      endcase
    end
  end

  assign halt     = r_halt;
  assign dmaaddr  = r_addr;
  assign dmawdata = r_wdata;
  assign dmawr    = r_wr;
  assign dmareq   = r_req;
  assign dmadone  = r_done;
  assign busy     = r_busy;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: a cycle-driven arbiter/RAM model feeds the DMA
// port while each scenario task checks the recorded transfer.
module tb_oam_dma;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  page;
  logic        cpudone;
  logic        cyctick;
  logic        halt;
  logic [15:0] dmaaddr;
  logic [7:0]  dmawdata;
  logic        dmawr;
  logic        dmareq;
  logic        dmaack;
  logic [7:0]  memrdata;
  logic        dmadone;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] rdAddr [256];
  logic [7:0]  wrVal  [256];
  int nReads, nWrites, nDone, nReqRise, nAcks;
  int nStableErr, nGapErr, nWrAddrErr, doneAtFirstReq;
  logic haltAt1, haltAt2, busyAt2;
  bit finished;

  oam_dma dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .page     (page),
    .cpudone  (cpudone),
    .cyctick  (cyctick),
    .halt     (halt),
    .dmaaddr  (dmaaddr),
    .dmawdata (dmawdata),
    .dmawr    (dmawr),
    .dmareq   (dmareq),
    .dmaack   (dmaack),
    .memrdata (memrdata),
    .dmadone  (dmadone),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Pulse start, then give the CPU-done strobe two clocks later.
  task automatic kickoff(input logic [7:0] p);
    @(negedge clk); start = 1'b1; page = p;
    @(negedge clk); start = 1'b0;
    @(negedge clk); cpudone = 1'b1;
    @(negedge clk); cpudone = 1'b0;
  endtask

  // Arbiter + RAM model. RAM[a] = a[7:0] ^ 8'h5A. Observes at negedge, drives
  // the next posedge. Stops after the final write retires, or on a pending
  // write at stopAtWrite.
  task automatic runEngine(input int stopAtWrite, input int delayRead,
                           input int secondStartAt, input bit strayAck);
    logic        prevReq = 1'b0;
    logic        justAcked = 1'b0;
    logic [15:0] holdAddr = '0;
    logic        holdWr = 1'b0;
    logic [7:0]  holdData = '0;
    int          waitCnt = 0;
    int          lastAckSeen = 0;
    bit          startDone = 1'b0;
    nReads = 0; nWrites = 0; nDone = 0; nReqRise = 0; nAcks = 0;
    nStableErr = 0; nGapErr = 0; nWrAddrErr = 0; doneAtFirstReq = -1;
    haltAt1 = 1'bx; haltAt2 = 1'bx; busyAt2 = 1'bx; finished = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      if (dmadone === 1'b1) nDone++;
      if (lastAckSeen == 1) begin
        haltAt1 = halt;
        lastAckSeen = 2;
      end else if (lastAckSeen == 2) begin
        haltAt2 = halt;
        busyAt2 = busy;
        finished = 1'b1;
        break;
      end
      if (justAcked && dmareq === 1'b1) nGapErr++;
      dmaack = 1'b0; start = 1'b0; cyctick = (cyc % 2 == 1);
      justAcked = 1'b0;
      if (dmareq === 1'b1) begin
        if (!prevReq) begin
          nReqRise++;
          holdAddr = dmaaddr; holdWr = dmawr; holdData = dmawdata; waitCnt = 0;
          if (nReqRise == 1) doneAtFirstReq = nDone;
        end else if (dmaaddr !== holdAddr || dmawr !== holdWr ||
                     (holdWr && dmawdata !== holdData)) begin
          nStableErr++;
        end
        if (dmawr === 1'b0) begin
          if (nReads == secondStartAt && !startDone) begin
            start = 1'b1; page = 8'h07; startDone = 1'b1;
          end
          if (waitCnt >= ((nReads == delayRead) ? 5 : 0)) begin
            dmaack = 1'b1; justAcked = 1'b1;
            memrdata = dmaaddr[7:0] ^ 8'h5A;
            if (nReads < 256) rdAddr[nReads] = dmaaddr;
            nReads++; nAcks++;
          end else begin
            waitCnt++;
          end
        end else begin
          if (nWrites == stopAtWrite) begin
            finished = 1'b1;
            break;
          end
          dmaack = 1'b1; justAcked = 1'b1;
          if (dmaaddr !== 16'h2004) nWrAddrErr++;
          if (nWrites < 256) wrVal[nWrites] = dmawdata;
          nWrites++; nAcks++;
          if (nWrites == 256) lastAckSeen = 1;
        end
      end else if (strayAck && halt === 1'b1) begin
        dmaack = 1'b1;
      end
      prevReq = justAcked ? 1'b0 : dmareq;
    end
    dmaack = 1'b0; start = 1'b0; cyctick = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; page = 8'h00; cpudone = 1'b0; cyctick = 1'b0;
    dmaack = 1'b0; memrdata = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL reset_halt: got %b want 0", halt); end
    checks++; if (dmareq !== 1'b0) begin errors++; $display("FAIL reset_dmareq: got %b want 0", dmareq); end
    checks++; if (dmawr !== 1'b0) begin errors++; $display("FAIL reset_dmawr: got %b want 0", dmawr); end
    checks++; if (dmadone !== 1'b0) begin errors++; $display("FAIL reset_dmadone: got %b want 0", dmadone); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (dmaaddr !== 16'h0000) begin errors++; $display("FAIL reset_dmaaddr: got %h want 0000", dmaaddr); end
    checks++; if (dmawdata !== 8'h00) begin errors++; $display("FAIL reset_dmawdata: got %h want 00", dmawdata); end
    rst = 1'b0;
  endtask

  // start and cpudone together: start latches, halt waits for the next cpudone.
  task automatic test_first_read;
    @(negedge clk); start = 1'b1; page = 8'h02; cpudone = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy: got %b want 1", busy); end
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL same_clk_cpudone_halt: got %b want 0", halt); end
    start = 1'b0; cpudone = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL halt_early: got %b want 0", halt); end
    cpudone = 1'b1;
    @(negedge clk);
    checks++; if (halt !== 1'b1) begin errors++; $display("FAIL halt_rise: got %b want 1", halt); end
    cpudone = 1'b0;
  endtask

  // Full page 02 copy with a 5-clk stalled ack on read 7 and a stray start at read 100.
  task automatic test_full_transfer;
    runEngine(-1, 7, 100, 1'b0);
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL full_timeout: got %b want 1", finished); end
    checks++; if (doneAtFirstReq != 1) begin errors++; $display("FAIL dummy_done_count: got %0d want 1", doneAtFirstReq); end
    checks++; if (rdAddr[0] !== 16'h0200) begin errors++; $display("FAIL first_read_addr: got %h want 0200", rdAddr[0]); end
    checks++; if (nReads != 256) begin errors++; $display("FAIL full_reads: got %0d want 256", nReads); end
    checks++; if (nWrites != 256) begin errors++; $display("FAIL full_writes: got %0d want 256", nWrites); end
    checks++; if (nDone != 513) begin errors++; $display("FAIL full_dmadone: got %0d want 513", nDone); end
    checks++; if (nReqRise != 512) begin errors++; $display("FAIL full_req_count: got %0d want 512", nReqRise); end
    checks++; if (nStableErr != 0) begin errors++; $display("FAIL full_stable: got %0d want 0", nStableErr); end
    checks++; if (nGapErr != 0) begin errors++; $display("FAIL full_gap: got %0d want 0", nGapErr); end
    checks++; if (nWrAddrErr != 0) begin errors++; $display("FAIL full_wr_addr: got %0d want 0", nWrAddrErr); end
    checks++; if (haltAt1 !== 1'b1) begin errors++; $display("FAIL halt_after_last_ack: got %b want 1", haltAt1); end
    checks++; if (haltAt2 !== 1'b0) begin errors++; $display("FAIL halt_fall: got %b want 0", haltAt2); end
    checks++; if (busyAt2 !== 1'b0) begin errors++; $display("FAIL busy_fall: got %b want 0", busyAt2); end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] idx;
      idx = 8'(i);
      checks++;
      if (rdAddr[i] !== {8'h02, idx}) begin
        errors++; $display("FAIL full_rd_addr[%0d]: got %h want %h", i, rdAddr[i], {8'h02, idx});
      end
      checks++;
      if (wrVal[i] !== (idx ^ 8'h5A)) begin
        errors++; $display("FAIL full_wr_data[%0d]: got %h want %h", i, wrVal[i], idx ^ 8'h5A);
      end
    end
  endtask

  task automatic test_reset_midtransfer;
    kickoff(8'h02);
    runEngine(40, -1, -1, 1'b0);
    checks++; if (nWrites != 40) begin errors++; $display("FAIL abort_writes: got %0d want 40", nWrites); end
    checks++; if (dmareq !== 1'b1 || dmawr !== 1'b1) begin errors++; $display("FAIL abort_pending_wr: got req=%b wr=%b want 1/1", dmareq, dmawr); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (halt !== 1'b0) begin errors++; $display("FAIL abort_halt: got %b want 0", halt); end
    checks++; if (dmareq !== 1'b0) begin errors++; $display("FAIL abort_dmareq: got %b want 0", dmareq); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    rst = 1'b0;
    kickoff(8'h02);
    runEngine(-1, -1, -1, 1'b0);
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL restart_timeout: got %b want 1", finished); end
    checks++; if (rdAddr[0] !== 16'h0200) begin errors++; $display("FAIL restart_first_addr: got %h want 0200", rdAddr[0]); end
    checks++; if (wrVal[0] !== 8'h5A) begin errors++; $display("FAIL restart_first_data: got %h want 5a", wrVal[0]); end
    checks++; if (nWrites != 256) begin errors++; $display("FAIL restart_writes: got %0d want 256", nWrites); end
    checks++; if (nDone != 513) begin errors++; $display("FAIL restart_dmadone: got %0d want 513", nDone); end
  endtask

  // Top page with acks thrown at every low-request clk while halted.
  task automatic test_page_ff;
    kickoff(8'hFF);
    runEngine(-1, -1, -1, 1'b1);
    checks++; if (finished !== 1'b1) begin errors++; $display("FAIL ff_timeout: got %b want 1", finished); end
    checks++; if (nReads != 256) begin errors++; $display("FAIL ff_reads: got %0d want 256", nReads); end
    checks++; if (nWrites != 256) begin errors++; $display("FAIL ff_writes: got %0d want 256", nWrites); end
    checks++; if (nDone != 513) begin errors++; $display("FAIL ff_dmadone: got %0d want 513", nDone); end
    checks++; if (rdAddr[255] !== 16'hFFFF) begin errors++; $display("FAIL ff_last_addr: got %h want ffff", rdAddr[255]); end
    for (int i = 0; i < 256; i++) begin
      logic [7:0] idx;
      idx = 8'(i);
      checks++;
      if (rdAddr[i] !== {8'hFF, idx}) begin
        errors++; $display("FAIL ff_rd_addr[%0d]: got %h want %h", i, rdAddr[i], {8'hFF, idx});
      end
      checks++;
      if (wrVal[i] !== (idx ^ 8'h5A)) begin
        errors++; $display("FAIL ff_wr_data[%0d]: got %h want %h", i, wrVal[i], idx ^ 8'h5A);
      end
    end
  endtask

  initial begin
    test_reset;
    test_first_read;
    test_full_transfer;
    test_reset_midtransfer;
    test_page_ff;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma.md
Name: oam_dma

Overview:
Sprite DMA engine for the $4014 write path. On a trigger it halts the CPU at its next bus-cycle boundary and copies 256 bytes from page XX00..XXFF to the PPU OAMDATA register. It uses the memory arbiter's DMA master port (halt, dmaaddr/dmawdata/dmawr/dmareq/dmaack, dmadone). Sits directly upstream of the memory arbiter, fed by the I/O register decode.

Parameters:
DEST_ADDR, 16'h2004, write target for every copied byte (OAMDATA)
LEN, 256, bytes per transfer; counter width is 9 bits
DUMMY, 1, idle CPU cycles after halt before the first read

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-clk pulse from the I/O decode on a CPU write to $4014
page  in  8  source page; valid with start
cpudone  in  1  one-clk strobe: CPU finished its current bus cycle
cyctick  in  1  one-clk CPU-cycle enable from the timing generator
halt  out  1  registered; selects the DMA master in the arbiter
dmaaddr  out  16  bus address
dmawdata  out  8  write data
dmawr  out  1  1 = write, 0 = read; valid while dmareq
dmareq  out  1  level request, held until dmaack
dmaack  in  1  one-clk acknowledge from the arbiter
memrdata  in  8  arbiter read data; valid in the cycle dmaack=1
dmadone  out  1  one-clk strobe per completed DMA bus cycle, dummy cycles included
busy  out  1  high from start until the clock after the final write ack

Behaviour:
- Reset: state IDLE; halt, dmareq, dmawr, dmadone and busy = 0; dmaaddr = 0; dmawdata = 0; index = 0. Reset mid-transfer aborts on the next edge. No write is retried.
- State machine: IDLE -> WAITHALT -> DUMMY -> RD -> WR -> (RD | FIN) -> IDLE.
- IDLE: on start, latch page, clear index, set busy, go to WAITHALT.
- WAITHALT: on cpudone, set halt on the next edge and go to DUMMY.
  - cpudone and start in the same clk: the start is latched; the halt waits for the following cpudone.
- DUMMY: count DUMMY cyctick pulses with no request. Pulse dmadone on each counted tick. Then go to RD.
- RD: on cyctick, assert dmareq=1, dmawr=0, dmaaddr={page,index[7:0]}.
  - On dmaack: capture memrdata into dmawdata, drop dmareq on the next edge, pulse dmadone, go to WR.
- WR: wait at least one clk with dmareq low, because the targets are rising-edge triggered. Then on cyctick assert dmareq=1, dmawr=1, dmaaddr=DEST_ADDR.
  - On dmaack: drop dmareq, pulse dmadone, index+1.
  - If index reaches LEN-1 before the increment, go to FIN; otherwise go to RD.
- FIN: clear halt and busy on the same edge, return to IDLE.
  - halt therefore falls one clk after the last write ack; dmadone of the last write precedes it.
- Handshake rules:
  - dmareq is never asserted for two consecutive accesses without an intervening low clk.
  - dmaaddr, dmawr and dmawdata are stable while dmareq is high.
  - An ack arriving while dmareq is low is ignored.
- Index is 9-bit and does not wrap into the next page: the source address is always {page, index[7:0]}.
- start while busy is ignored; page is not re-latched.
- cyctick and dmaack in the same clk: the ack is processed first, and the new request waits for the next cyctick.
- An access stalls indefinitely until dmaack arrives; there is no timeout.

Decomposition:
- The shared header holds the state encoding constants (DMA_IDLE..DMA_FIN) and the OAMDATA address 16'h2004 beside the mirroring constants.
- A sub-module is not natural; keep it flat. The req/ack edge discipline is about 20 lines in-line.

Test Plan:
- start page=8'h02, cpudone 3 clk later -> halt rises 1 clk after cpudone; first read addr 16'h0200 after 1 dummy dmadone.
- Full transfer from a model where RAM[0x0200+i]=i^8'h5A -> 256 writes to 16'h2004 carrying values i^8'h5A in order; 513 dmadone pulses in total; halt falls 1 clk after the 256th write ack.
- Slave delays ack 5 clk on read index 7 -> dmareq held high with a stable address; no duplicate request; data captured correctly.
- Second start at index 100 with page=8'h07 -> ignored; all reads stay in page 8'h02.
- rst asserted during WR at index 40 -> next clk: halt=0, dmareq=0, busy=0; a new start then restarts from index 0.
- page=8'hFF -> reads 16'hFF00..16'hFFFF with no wrap into 16'h0000; ack given while dmareq=0 -> no state change.
